// File: rtl/instruction_prefetch_unit.sv
// ============================================================================
// instruction_prefetch_unit
//
// Purpose:
//   Issues in-order word-address fetch requests to instruction memory. It
//   buffers the returned instructions with their PCs in a small prefetch queue
//   and presents the queue head to decode. The redirect commands (branch miss,
//   return, taken branch and jump) flush the queue and restart fetching at the
//   new target. Responses to requests that were in flight at the redirect are
//   dropped as they arrive.
//
// Build option:
//   IFQ_BYPASS_EN - when defined, a kept response that arrives while the queue
//                   is empty is presented to decode in its arrival cycle. If
//                   decode takes it in that cycle, it is never written to the
//                   queue.
//
// Ports:
//   iClk, iReset                   clock, asynchronous active-high reset
//   oInstrMemAddress/oInstrMemValid/iInstrMemReady
//                                  fetch request handshake
//   iInstrMemDataValid/iInstrMemData
//                                  in-order fetch responses
//   oInstruction/oInstrPC/oNextPC/oInstrValid/iDecodeReady
//                                  queue head towards decode
//   iBranchMissCmd/iBranchMissAddr, iRetCmd/iRetAddr,
//   iBranchCmd/iBranchAddr, iJumpCmd/iOffset
//                                  redirect commands, in priority order
//   iHalt                          suspend new requests
// ============================================================================
module instruction_prefetch_unit #(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter int unsigned            DEPTH        = 4,
    parameter int unsigned            OFFSET_WIDTH = 26,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC     = '0
) (
    input  logic                    iClk,
    input  logic                    iReset,
    output logic [ADDR_WIDTH-1:0]   oInstrMemAddress,
    output logic                    oInstrMemValid,
    input  logic                    iInstrMemReady,
    input  logic                    iInstrMemDataValid,
    input  logic [DATA_WIDTH-1:0]   iInstrMemData,
    output logic [DATA_WIDTH-1:0]   oInstruction,
    output logic [ADDR_WIDTH-1:0]   oInstrPC,
    output logic [ADDR_WIDTH-1:0]   oNextPC,
    output logic                    oInstrValid,
    input  logic                    iDecodeReady,
    input  logic                    iBranchMissCmd,
    input  logic [ADDR_WIDTH-1:0]   iBranchMissAddr,
    input  logic                    iRetCmd,
    input  logic [ADDR_WIDTH-1:0]   iRetAddr,
    input  logic                    iBranchCmd,
    input  logic [ADDR_WIDTH-1:0]   iBranchAddr,
    input  logic                    iJumpCmd,
    input  logic [OFFSET_WIDTH-1:0] iOffset,
    input  logic                    iHalt
);

    localparam int unsigned PW = $clog2(DEPTH);   // queue pointer width
    localparam int unsigned CW = PW + 1;          // holds 0..DEPTH
    localparam int unsigned OW = PW + 3;          // holds queued+outstanding+discard

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_q_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_pc    [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_discard;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;     // PC of the next response that is kept
    logic                  r_hold;        // request offered but not yet taken

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                  w_redirect;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_head_pc;
    logic [ADDR_WIDTH-1:0] w_jump_target;
    logic [OW-1:0]         w_occ;
    logic                  w_room;
    logic                  w_req_valid;
    logic                  w_accept;
    logic                  w_resp_discard;
    logic                  w_resp_out;
    logic                  w_keep;
    logic                  w_empty;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_instr_pc;

    assign w_redirect = iBranchMissCmd | iRetCmd | iBranchCmd | iJumpCmd;
    assign w_empty    = (r_count == '0);

    // The jump base uses the queued head only. Bypass is never active in a
    // redirect cycle, so this equals oInstrPC whenever a jump is taken. It
    // also keeps the response path out of the jump target logic.
    assign w_head_pc     = w_empty ? '0 : r_q_pc[r_rd_ptr];
    assign w_jump_target = {w_head_pc[ADDR_WIDTH-1:OFFSET_WIDTH], iOffset};

    always_comb begin
        w_target = w_jump_target;
        if (iBranchMissCmd) begin
            w_target = iBranchMissAddr;
        end else if (iRetCmd) begin
            w_target = iRetAddr;
        end else if (iBranchCmd) begin
            w_target = iBranchAddr;
        end
    end

    // Each kept, in-flight or to-be-dropped response needs a reserved slot.
    assign w_occ  = OW'(r_count) + OW'(r_outstanding) + OW'(r_discard);
    assign w_room = (w_occ < OW'(DEPTH));

    // Once a request has been offered, it stays up until it is accepted, even
    // if iHalt rises. Only a redirect or a reset withdraws it.
    assign w_req_valid = !iReset && !w_redirect && (r_hold || (!iHalt && w_room));
    assign w_accept    = w_req_valid && iInstrMemReady;

    // Pending discards are older than any live request, so they are retired
    // first. A response with nothing in flight is ignored.
    assign w_resp_discard = iInstrMemDataValid && (r_discard != '0);
    assign w_resp_out     = iInstrMemDataValid && (r_discard == '0) && (r_outstanding != '0);
    assign w_keep         = w_resp_out && !w_redirect;

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_keep && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop  = !w_empty && iDecodeReady && !w_redirect;
    assign w_push = w_keep && !(w_bypass && iDecodeReady);

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign oInstrMemAddress = r_fetch_pc;
    assign oInstrMemValid   = w_req_valid;

    assign w_instr_pc   = w_bypass ? r_resp_pc : w_head_pc;
    assign oInstrPC     = w_instr_pc;
    assign oNextPC      = w_instr_pc + ADDR_WIDTH'(1);
    assign oInstrValid  = !w_empty || w_bypass;
    assign oInstruction = w_bypass ? iInstrMemData :
                          (w_empty ? '0 : r_q_instr[r_rd_ptr]);

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_hold        <= 1'b0;
        end else if (w_redirect) begin
            r_fetch_pc    <= w_target;
            r_resp_pc     <= w_target;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            // A response arriving now retires one entry. Whatever is still in
            // flight afterwards must be dropped as it arrives.
            r_discard     <= r_discard - CW'(w_resp_discard)
                             + r_outstanding - CW'(w_resp_out);
            r_hold        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
            end
            if (w_keep) begin
                r_resp_pc <= r_resp_pc + ADDR_WIDTH'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_resp_out);
            r_discard     <= r_discard - CW'(w_resp_discard);
            r_hold        <= w_req_valid && !iInstrMemReady;
        end
    end

    // ------------------------------------------------------------------------
    // Queue storage (no reset needed; validity is tracked by r_count)
    // ------------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= iInstrMemData;
            r_q_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// ============================================================================
// tb_instruction_prefetch_unit
//
// Purpose:
//   Self-checking bench for instruction_prefetch_unit (default parameters).
//   A behavioural memory answers accepted requests in order after at least
//   one cycle. A reference model tracks the expected fetch PC, the dropped
//   responses and the expected decode stream. Define IFQ_BYPASS_EN for both
//   the bench and the design to check the bypass build.
// ============================================================================
module tb_instruction_prefetch_unit;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int OFW   = 26;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           iClk;
    logic           iReset;
    logic [AW-1:0]  oInstrMemAddress;
    logic           oInstrMemValid;
    logic           iInstrMemReady;
    logic           iInstrMemDataValid;
    logic [DW-1:0]  iInstrMemData;
    logic [DW-1:0]  oInstruction;
    logic [AW-1:0]  oInstrPC;
    logic [AW-1:0]  oNextPC;
    logic           oInstrValid;
    logic           iDecodeReady;
    logic           iBranchMissCmd;
    logic [AW-1:0]  iBranchMissAddr;
    logic           iRetCmd;
    logic [AW-1:0]  iRetAddr;
    logic           iBranchCmd;
    logic [AW-1:0]  iBranchAddr;
    logic           iJumpCmd;
    logic [OFW-1:0] iOffset;
    logic           iHalt;

    instruction_prefetch_unit #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .OFFSET_WIDTH (OFW),
        .RESET_PC     (32'h0)
    ) dut (
        .iClk               (iClk),
        .iReset             (iReset),
        .oInstrMemAddress   (oInstrMemAddress),
        .oInstrMemValid     (oInstrMemValid),
        .iInstrMemReady     (iInstrMemReady),
        .iInstrMemDataValid (iInstrMemDataValid),
        .iInstrMemData      (iInstrMemData),
        .oInstruction       (oInstruction),
        .oInstrPC           (oInstrPC),
        .oNextPC            (oNextPC),
        .oInstrValid        (oInstrValid),
        .iDecodeReady       (iDecodeReady),
        .iBranchMissCmd     (iBranchMissCmd),
        .iBranchMissAddr    (iBranchMissAddr),
        .iRetCmd            (iRetCmd),
        .iRetAddr           (iRetAddr),
        .iBranchCmd         (iBranchCmd),
        .iBranchAddr        (iBranchAddr),
        .iJumpCmd           (iJumpCmd),
        .iOffset            (iOffset),
        .iHalt              (iHalt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
    } sb_t;

    sb_t           sb[$];        // expected decode stream
    logic [AW-1:0] mem_q[$];     // accepted requests awaiting a response
    logic [AW-1:0] acc_log[$];
    logic [AW-1:0] pop_log[$];
    int            n_checks;
    int            n_fail;
    int            drop_cnt;
    int            n_acc;
    int            n_pop;
    logic [AW-1:0] exp_pc;
    bit            mem_en;
    bit            prev_stall;
    logic [AW-1:0] prev_addr;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_cmds();
        iBranchMissCmd = 1'b0;
        iRetCmd        = 1'b0;
        iBranchCmd     = 1'b0;
        iJumpCmd       = 1'b0;
    endtask

    // One clock cycle, entered and left at the falling edge. chk_iv >= 0 adds
    // an explicit check of oInstrValid for this cycle.
    task automatic cycle(input int chk_iv);
        logic          redirect;
        logic          pushed;
        logic [AW-1:0] tgt;
        logic [AW-1:0] hp;
        logic [AW-1:0] a;
        int            n_vis;
        sb_t           e;
        redirect = iBranchMissCmd | iRetCmd | iBranchCmd | iJumpCmd;
        hp       = (sb.size() > 0) ? sb[0].pc : 32'h0;
        if (iBranchMissCmd)  tgt = iBranchMissAddr;
        else if (iRetCmd)    tgt = iRetAddr;
        else if (iBranchCmd) tgt = iBranchAddr;
        else                 tgt = {hp[31:26], iOffset};

        pushed = 1'b0;
        if (mem_en && mem_q.size() > 0) begin
            a                  = mem_q.pop_front();
            iInstrMemDataValid = 1'b1;
            iInstrMemData      = mem_data(a);
            if (!redirect) begin
                if (drop_cnt > 0) begin
                    drop_cnt--;
                end else begin
                    e.pc  = a;
                    e.ins = mem_data(a);
                    sb.push_back(e);
                    pushed = 1'b1;
                end
            end
        end else begin
            iInstrMemDataValid = 1'b0;
            iInstrMemData      = $urandom();
        end
        #1;
        if (chk_iv >= 0) check_eq("instr_valid_timing", {31'b0, oInstrValid}, chk_iv);
        if (prev_stall && !redirect) begin
            check_eq("req_hold_valid", {31'b0, oInstrMemValid}, 32'd1);
            check_eq("req_hold_addr", oInstrMemAddress, prev_addr);
        end
        if (redirect) check_eq("redirect_no_req", {31'b0, oInstrMemValid}, 32'd0);

        // Without bypass, a response pushed this cycle is not visible yet.
        n_vis = sb.size() - ((pushed && !BYP) ? 1 : 0);
        check_eq("instr_valid", {31'b0, oInstrValid}, (n_vis > 0) ? 32'd1 : 32'd0);
        if (n_vis > 0) begin
            check_eq("head_pc", oInstrPC, sb[0].pc);
            check_eq("head_instr", oInstruction, sb[0].ins);
            check_eq("next_pc", oNextPC, sb[0].pc + 32'd1);
            if (oInstrValid && iDecodeReady && !redirect) begin
                e = sb.pop_front();
                pop_log.push_back(e.pc);
                n_pop++;
            end
        end

        if (oInstrMemValid && iInstrMemReady) begin
            check_eq("req_addr", oInstrMemAddress, exp_pc);
            mem_q.push_back(exp_pc);
            acc_log.push_back(oInstrMemAddress);
            n_acc++;
            exp_pc = exp_pc + 32'd1;
        end
        prev_stall = oInstrMemValid && !iInstrMemReady;
        prev_addr  = oInstrMemAddress;
        if (redirect) begin
            drop_cnt += mem_q.size();
            sb.delete();
            exp_pc = tgt;
        end
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(-1);
    endtask

    // Reset for one full cycle, starting at a falling edge. The memory model
    // forgets everything in flight.
    task automatic do_reset();
        iReset             = 1'b1;
        iInstrMemDataValid = 1'b0;
        clear_cmds();
        #1;
        check_eq("rst_req_valid", {31'b0, oInstrMemValid}, 32'd0);
        check_eq("rst_instr_valid", {31'b0, oInstrValid}, 32'd0);
        check_eq("rst_instr", oInstruction, 32'd0);
        check_eq("rst_pc", oInstrPC, 32'd0);
        check_eq("rst_next_pc", oNextPC, 32'd1);
        mem_q.delete();
        sb.delete();
        drop_cnt   = 0;
        exp_pc     = 32'h0;
        prev_stall = 1'b0;
        @(posedge iClk);
        #1;
        check_eq("rst_req_valid_edge", {31'b0, oInstrMemValid}, 32'd0);
        check_eq("rst_instr_valid_edge", {31'b0, oInstrValid}, 32'd0);
        @(negedge iClk);
        iReset = 1'b0;
        #1;
        check_eq("first_req_valid", {31'b0, oInstrMemValid}, iHalt ? 32'd0 : 32'd1);
        check_eq("first_req_addr", oInstrMemAddress, 32'h0);
    endtask

    initial begin
        int p0;
        n_checks = 0;
        n_fail   = 0;
        n_acc    = 0;
        n_pop    = 0;
        drop_cnt = 0;
        iReset   = 1'b1;
        iInstrMemReady     = 1'b1;
        iInstrMemDataValid = 1'b0;
        iInstrMemData      = '0;
        iDecodeReady       = 1'b1;
        iBranchMissAddr    = '0;
        iRetAddr           = '0;
        iBranchAddr        = '0;
        iOffset            = '0;
        iHalt              = 1'b0;
        mem_en             = 1'b1;
        clear_cmds();
        @(negedge iClk);

        // Streaming with a one-cycle memory: no gaps once the pipe is full.
        do_reset();
        pop_log.delete();
        run(5);
        p0 = n_pop;
        run(15);
        check_eq("stream_no_gaps", n_pop - p0, 32'd15);
        check_eq("stream_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD, 32'h0);

        // Reset in the middle of the stream, then restart at address 0.
        do_reset();
        run(6);

        // Backpressure: decode stalled, only DEPTH requests go out.
        iDecodeReady = 1'b0;
        do_reset();
        n_acc = 0;
        run(10);
        check_eq("bp_req_count", n_acc, DEPTH);
        check_eq("bp_req_idle", {31'b0, oInstrMemValid}, 32'd0);
        iDecodeReady = 1'b1;
        n_acc = 0;
        cycle(-1);
        iDecodeReady = 1'b0;
        run(3);
        check_eq("bp_req_after_pop", n_acc, 32'd1);

        // Priority: branch miss wins over branch, two in-flight responses dropped.
        iBranchCmd = 1'b1;
        iBranchAddr = 32'h50;
        cycle(-1);
        clear_cmds();
        mem_en = 1'b0;
        run(2);
        check_eq("prio_outstanding", mem_q.size(), 32'd2);
        iBranchMissCmd  = 1'b1;
        iBranchMissAddr = 32'h100;
        iBranchCmd      = 1'b1;
        iBranchAddr     = 32'h200;
        acc_log.delete();
        pop_log.delete();
        cycle(-1);
        clear_cmds();
        mem_en       = 1'b1;
        iDecodeReady = 1'b1;
        run(8);
        check_eq("prio_first_req", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD, 32'h100);
        check_eq("prio_first_pop", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD, 32'h100);

        // Jump target from the head PC, then wrap of the fetch PC.
        iDecodeReady = 1'b0;
        iBranchCmd   = 1'b1;
        iBranchAddr  = 32'hFC00_0010;
        cycle(-1);
        clear_cmds();
        run(4);
        check_eq("jump_head_pc", oInstrPC, 32'hFC00_0010);
        iJumpCmd = 1'b1;
        iOffset  = 26'h3FF_FFFF;
        acc_log.delete();
        cycle(-1);
        clear_cmds();
        iDecodeReady = 1'b1;
        run(6);
        check_eq("jump_req0", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD, 32'hFFFF_FFFF);
        check_eq("jump_req1", (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD, 32'h0);

        // Response-to-valid latency with an empty queue.
        iHalt = 1'b1;
        run(8);
        iHalt = 1'b0;
        cycle(0);
        iHalt = 1'b1;
        cycle(BYP ? 1 : 0);
        cycle(BYP ? 0 : 1);
        iHalt = 1'b0;

        // Random traffic with all redirect kinds.
        for (int i = 0; i < 400; i++) begin
            iInstrMemReady = ($urandom_range(0, 3) != 0);
            iDecodeReady   = ($urandom_range(0, 2) != 0);
            mem_en         = ($urandom_range(0, 3) != 0);
            iHalt          = ($urandom_range(0, 9) == 0);
            clear_cmds();
            if ($urandom_range(0, 24) == 0) begin
                iBranchMissCmd  = $urandom_range(0, 1);
                iRetCmd         = $urandom_range(0, 1);
                iBranchCmd      = $urandom_range(0, 1);
                iJumpCmd        = 1'b1;
                iBranchMissAddr = $urandom();
                iRetAddr        = $urandom();
                iBranchAddr     = $urandom();
                iOffset         = OFW'($urandom());
            end
            cycle(-1);
        end
        clear_cmds();
        iHalt          = 1'b0;
        iInstrMemReady = 1'b1;
        iDecodeReady   = 1'b1;
        mem_en         = 1'b1;
        run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
